cmp_duty_reporter: RTL and testbench

- Sequencer between the LVDS comparator input and the `acia_tx` UART transmitter.
- Synchronises the comparator bit and counts high samples over a fixed window of clocks.
- At each window end, snapshots the count and drives `acia_tx` byte by byte over the `tx_start`/`tx_busy` handshake.
- Frame format: header byte, count bytes MSB-first, trailer byte. Replaces the free-running single-byte trigger in the LVDS top level.

---
 rtl/cmp_duty_reporter_if.sv | 14 +
 rtl/cmp_duty_reporter.sv | 127 ++++++++++++
 tb/tb_cmp_duty_reporter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_duty_reporter_if.sv
// cmp_duty_reporter_if -- byte handshake between the duty reporter and the
// acia_tx UART transmitter.
//   tx_dat   : byte presented to the transmitter
//   tx_start : single-cycle transmit request
//   tx_busy  : transmitter is shifting a byte out
// master = reporter side, slave = transmitter side.
interface cmp_duty_reporter_if;
  logic [7:0] tx_dat;
  logic       tx_start;
  logic       tx_busy;

  modport master (output tx_dat, output tx_start, input tx_busy);
  modport slave  (input tx_dat, input tx_start, output tx_busy);
endinterface

// File: rtl/cmp_duty_reporter.sv
// cmp_duty_reporter -- counts high samples of the synchronised LVDS comparator
// bit over a fixed window of WIN_CNT clocks and reports each window count to
// acia_tx as a frame: HDR, NB count bytes (MSB first), TRL.
// Ports:
//   clk, rst     : system clock, asynchronous active-low reset
//   en           : measurement enable (windows run only while high)
//   comp_in      : raw comparator bit, asynchronous to clk
//   tx           : byte handshake to acia_tx (master side)
//   frame_active : high from first byte load until the trailer completes
//   last_count   : most recent accepted window count
//   ovr_cnt      : windows dropped because a frame was still running (saturating)
module cmp_duty_reporter #(
  parameter int         WIN_CNT = 4800000,
  parameter int         CW      = $clog2(WIN_CNT+1),
  parameter int         NB      = 3,
  parameter logic [7:0] HDR     = 8'h53,
  parameter logic [7:0] TRL     = 8'h0A
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                comp_in,
  cmp_duty_reporter_if.master tx,
  output logic                frame_active,
  output logic [CW-1:0]       last_count,
  output logic [7:0]          ovr_cnt
);

  localparam int            IW       = $clog2(NB+2);
  localparam logic [CW-1:0] WIN_LAST = CW'(WIN_CNT-1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NB+1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO} state_t;

  logic [1:0]      sync;
  logic            s;
  logic [CW-1:0]   win_ctr, hi_ctr;
  logic            snap_vld;
  logic [CW-1:0]   snap;
  logic [8*NB-1:0] cnt_ext;
  state_t          state;
  logic [IW-1:0]   idx, idx_nxt;

  assign s        = sync[1];
  assign snap_vld = en && (win_ctr == WIN_LAST);
  // Includes the final sample of the window, so range is 0..WIN_CNT.
  assign snap     = hi_ctr + CW'(s);
  assign cnt_ext  = (8*NB)'(last_count);
  assign idx_nxt  = idx + 1'b1;

  // Frame byte for a given index: header, count bytes MSB first, trailer.
  function automatic logic [7:0] byte_at(input logic [IW-1:0] i,
                                         input logic [8*NB-1:0] c);
    logic [7:0] b;
    b = TRL;
    if (i == '0) b = HDR;
    for (int k = 1; k <= NB; k++)
      if (i == IW'(k)) b = c[8*(NB-k) +: 8];
    return b;
  endfunction

  // Synchroniser and measurement window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync    <= 2'b00;
      win_ctr <= '0;
      hi_ctr  <= '0;
    end else begin
      sync <= {sync[0], comp_in};
      if (!en || win_ctr == WIN_LAST) begin
        win_ctr <= '0;
        hi_ctr  <= '0;
      end else begin
        win_ctr <= win_ctr + 1'b1;
        hi_ctr  <= snap;
      end
    end
  end

  // Snapshot acceptance and frame sequencer. Only an IDLE state at the edge
  // accepts a snapshot; anything else (including the WAIT_LO->IDLE edge)
  // is an overrun. tx_dat is loaded on entry to LOAD and held until the
  // next LOAD so it is stable across START/WAIT_HI/WAIT_LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      idx          <= '0;
      tx.tx_dat    <= 8'h00;
      tx.tx_start  <= 1'b0;
      frame_active <= 1'b0;
      last_count   <= '0;
      ovr_cnt      <= 8'h00;
    end else begin
      tx.tx_start <= 1'b0;
      if (snap_vld) begin
        if (state == IDLE)         last_count <= snap;
        else if (ovr_cnt != 8'hFF) ovr_cnt    <= ovr_cnt + 1'b1;
      end
      case (state)
        IDLE: if (snap_vld) begin
          state        <= LOAD;
          idx          <= '0;
          tx.tx_dat    <= HDR;
          frame_active <= 1'b1;
        end
        LOAD: if (!tx.tx_busy) begin
          state       <= START;
          tx.tx_start <= 1'b1;
        end
        START:   state <= WAIT_HI;
        WAIT_HI: if (tx.tx_busy) state <= WAIT_LO;
        WAIT_LO: if (!tx.tx_busy) begin
          if (idx == IDX_LAST) begin
            state        <= IDLE;
            frame_active <= 1'b0;
          end else begin
            idx       <= idx_nxt;
            tx.tx_dat <= byte_at(idx_nxt, cnt_ext);
            state     <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_duty_reporter.sv
// Directed bench for cmp_duty_reporter. Two instances:
//   A: WIN_CNT=100, NB=1 (frames, busy stall, enable gating, async reset)
//   B: WIN_CNT=20,  NB=2 (toggling input, overruns, ovr_cnt saturation)
// Each instance has a small acia_tx model: busy rises the cycle after a
// start pulse and stays high for a programmable number of clocks.
module tb_cmp_duty_reporter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---- instance A ----
  logic       rst_a, en_a, comp_a, force_a;
  int         len_a;
  logic       fa_a;
  logic [6:0] lc_a;
  logic [7:0] ovr_a;
  cmp_duty_reporter_if ifa ();

  cmp_duty_reporter #(.WIN_CNT(100), .NB(1)) u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .comp_in(comp_a), .tx(ifa),
    .frame_active(fa_a), .last_count(lc_a), .ovr_cnt(ovr_a));

  // ---- instance B ----
  logic       rst_b, en_b, comp_b, tog_en_b;
  logic       tog_b = 1'b0;
  logic       comp_b_in;
  int         len_b;
  logic       fa_b;
  logic [4:0] lc_b;
  logic [7:0] ovr_b;
  cmp_duty_reporter_if ifb ();

  always @(posedge clk) tog_b <= ~tog_b;
  assign comp_b_in = tog_en_b ? tog_b : comp_b;

  cmp_duty_reporter #(.WIN_CNT(20), .NB(2)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .comp_in(comp_b_in), .tx(ifb),
    .frame_active(fa_b), .last_count(lc_b), .ovr_cnt(ovr_b));

  // ---- UART models and monitors ----
  int rem_a, rem_b;
  int viol_a = 0, viol_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  always @(posedge clk or negedge rst_a)
    if (!rst_a)               rem_a <= 0;
    else if (ifa.tx_start)    rem_a <= len_a;
    else if (rem_a > 0)       rem_a <= rem_a - 1;
  assign ifa.tx_busy = (rem_a != 0) | force_a;

  always @(posedge clk or negedge rst_b)
    if (!rst_b)               rem_b <= 0;
    else if (ifb.tx_start)    rem_b <= len_b;
    else if (rem_b > 0)       rem_b <= rem_b - 1;
  assign ifb.tx_busy = (rem_b != 0);

  // Capture every started byte; flag starts while busy or wider than 1 clk.
  always @(posedge clk) begin
    if (rst_a && ifa.tx_start) begin
      qa.push_back(ifa.tx_dat);
      if (ifa.tx_busy || prev_a) viol_a <= viol_a + 1;
    end
    prev_a <= ifa.tx_start;
  end

  always @(posedge clk) begin
    if (rst_b && ifb.tx_start) begin
      qb.push_back(ifb.tx_dat);
      if (ifb.tx_busy || prev_b) viol_b <= viol_b + 1;
    end
    prev_b <= ifb.tx_start;
  end

  // ---- helpers ----
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_bytes(input bit sel, input int n, input int budget, input string tag);
    int k = 0;
    while (((sel ? qb.size() : qa.size()) < n) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'((sel ? qb.size() : qa.size()) >= n), 32'd1);
  endtask

  task automatic wait_idle_b(input int budget, input string tag);
    int k = 0;
    while (fa_b && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(fa_b), 32'd0);
  endtask

  // ---- directed sequence ----
  initial begin
    int b;
    rst_a = 0; en_a = 0; comp_a = 0; force_a = 0; len_a = 10;
    rst_b = 0; en_b = 0; comp_b = 0; tog_en_b = 0; len_b = 30;
    cyc(3);

    // Reset state
    chk("rst_a_dat",   32'(ifa.tx_dat),   32'h0);
    chk("rst_a_start", 32'(ifa.tx_start), 32'h0);
    chk("rst_a_fa",    32'(fa_a),         32'h0);
    chk("rst_a_lc",    32'(lc_a),         32'h0);
    chk("rst_a_ovr",   32'(ovr_a),        32'h0);
    chk("rst_b_dat",   32'(ifb.tx_dat),   32'h0);
    chk("rst_b_fa",    32'(fa_b),         32'h0);

    // A1: comp_in held high. First window loses 2 samples to the
    // synchroniser (98 = 0x62); the second is a full 100 (0x64).
    comp_a = 1; en_a = 1; rst_a = 1;
    b = qa.size();
    wait_bytes(0, b + 6, 400, "a1_wait");
    chk("a1_f1_hdr", 32'(qa[b]),   32'h53);
    chk("a1_f1_cnt", 32'(qa[b+1]), 32'h62);
    chk("a1_f1_trl", 32'(qa[b+2]), 32'h0A);
    chk("a1_f2_hdr", 32'(qa[b+3]), 32'h53);
    chk("a1_f2_cnt", 32'(qa[b+4]), 32'h64);
    chk("a1_f2_trl", 32'(qa[b+5]), 32'h0A);
    chk("a1_lc",     32'(lc_a),    32'd100);
    chk("a1_ovr",    32'(ovr_a),   32'd0);

    // A2: busy forced high before the first snapshot -> parked in LOAD.
    rst_a = 0; force_a = 1;
    cyc(2);
    rst_a = 1;
    b = qa.size();
    cyc(150);
    chk("a2_fa",     32'(fa_a),        32'd1);
    chk("a2_dat",    32'(ifa.tx_dat),  32'h53);
    chk("a2_nostart",32'(qa.size()),   32'(b));
    force_a = 0;
    wait_bytes(0, b + 1, 5, "a2_wait");
    chk("a2_hdr",    32'(qa[b]),       32'h53);
    cyc(2);
    chk("a2_onepulse", 32'(qa.size()), 32'(b + 1));

    // A3: en low for 3+ windows, then high -> only the full window after
    // en rose is counted (synchroniser already settled at 1).
    rst_a = 0; en_a = 0; comp_a = 1;
    cyc(2);
    rst_a = 1;
    b = qa.size();
    cyc(350);
    chk("a3_noframe", 32'(qa.size()), 32'(b));
    chk("a3_lc0",     32'(lc_a),      32'd0);
    chk("a3_fa0",     32'(fa_a),      32'd0);
    en_a = 1;
    wait_bytes(0, b + 3, 200, "a3_wait");
    chk("a3_hdr", 32'(qa[b]),   32'h53);
    chk("a3_cnt", 32'(qa[b+1]), 32'h64);
    chk("a3_trl", 32'(qa[b+2]), 32'h0A);

    // A4: async reset during WAIT_LO of the count byte.
    rst_a = 0;
    cyc(2);
    rst_a = 1;
    b = qa.size();
    wait_bytes(0, b + 2, 200, "a4_wait");
    cyc(3);
    chk("a4_pre_fa",  32'(fa_a),       32'd1);
    chk("a4_pre_dat", 32'(ifa.tx_dat), 32'h62);
    #2 rst_a = 0;
    #1;
    chk("a4_dat",   32'(ifa.tx_dat),   32'h0);
    chk("a4_start", 32'(ifa.tx_start), 32'h0);
    chk("a4_fa",    32'(fa_a),         32'h0);
    chk("a4_lc",    32'(lc_a),         32'h0);
    chk("a4_ovr",   32'(ovr_a),        32'h0);
    cyc(2);
    b = qa.size();
    rst_a = 1;
    wait_bytes(0, b + 2, 200, "a4_wait2");
    chk("a4_hdr", 32'(qa[b]),   32'h53);
    chk("a4_cnt", 32'(qa[b+1]), 32'h62);
    chk("a_viol", 32'(viol_a),  32'd0);

    // B1: toggling input, 10-clk busy. First window 9 (sync warm-up),
    // steady state 10. Frame is 52 clks, so two windows drop meanwhile.
    len_b = 10; tog_en_b = 1; en_b = 1; rst_b = 1;
    b = qb.size();
    wait_bytes(1, b + 4, 100, "b1_wait1");
    wait_idle_b(100, "b1_idle");
    chk("b1_ovr", 32'(ovr_b), 32'd2);
    wait_bytes(1, b + 8, 200, "b1_wait2");
    chk("b1_f1_hdr", 32'(qb[b]),   32'h53);
    chk("b1_f1_msb", 32'(qb[b+1]), 32'h00);
    chk("b1_f1_lsb", 32'(qb[b+2]), 32'h09);
    chk("b1_f1_trl", 32'(qb[b+3]), 32'h0A);
    chk("b1_f2_hdr", 32'(qb[b+4]), 32'h53);
    chk("b1_f2_msb", 32'(qb[b+5]), 32'h00);
    chk("b1_f2_lsb", 32'(qb[b+6]), 32'h0A);
    chk("b1_f2_trl", 32'(qb[b+7]), 32'h0A);

    // B2: 30-clk busy -> 132-clk frames, 6 windows dropped per frame.
    rst_b = 0; tog_en_b = 0; comp_b = 1; len_b = 30;
    cyc(2);
    rst_b = 1;
    b = qb.size();
    wait_bytes(1, b + 4, 300, "b2_wait1");
    wait_idle_b(200, "b2_idle");
    chk("b2_ovr6", 32'(ovr_b), 32'd6);
    chk("b2_lc",   32'(lc_b),  32'd18);
    wait_bytes(1, b + 8, 300, "b2_wait2");
    chk("b2_f1_hdr", 32'(qb[b]),   32'h53);
    chk("b2_f1_msb", 32'(qb[b+1]), 32'h00);
    chk("b2_f1_lsb", 32'(qb[b+2]), 32'h12);
    chk("b2_f1_trl", 32'(qb[b+3]), 32'h0A);
    chk("b2_f2_hdr", 32'(qb[b+4]), 32'h53);
    chk("b2_f2_lsb", 32'(qb[b+6]), 32'h14);
    chk("b2_f2_trl", 32'(qb[b+7]), 32'h0A);
    cyc(7000);
    chk("b2_sat",  32'(ovr_b),  32'd255);
    chk("b2_lc20", 32'(lc_b),   32'd20);
    chk("b_viol",  32'(viol_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
